// File: rtl/cic_pkg.sv
// Shared mode encoding and the width rule for the CIC decimator family.
package cic_pkg;

  typedef enum logic {
    MODE_INCR = 1'b0,
    MODE_CONT = 1'b1
  } cic_mode_e;

  // Integrator growth is ORDER*log2(R) bits above the 1-bit input.
  function automatic int min_out_w(input int order, input int log2_r_max);
    return order * log2_r_max + 1;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC differentiator: y = x - x_prev, delay register advanced on en.
module cic_comb_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  logic [W-1:0] dly;

  assign y = x - dly;

  always_ff @(posedge clk) begin
    if (reset || clear) dly <= '0;
    else if (en)        dly <= x;
  end

endmodule

// File: rtl/cic_decimator.sv
// ORDER-stage CIC decimator for a 1-bit modulator stream, power-of-two ratio,
// incremental (integrate-and-dump) or continuous (free-running) operation.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int OUT_W      = 16,
  parameter int ORDER      = 2,
  parameter int LOG2_R_MAX = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             bit_in,
  input  logic             in_valid,
  input  logic             mode,
  input  logic [2:0]       dec_log2,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid
);

  localparam int         CNT_W   = LOG2_R_MAX;
  localparam logic [2:0] DEC_MAX = 3'(LOG2_R_MAX);

  if (OUT_W < min_out_w(ORDER, LOG2_R_MAX)) begin : g_width_chk
    $error("cic_decimator: OUT_W too small for ORDER and LOG2_R_MAX");
  end
  if (ORDER < 1 || ORDER > 3) begin : g_order_chk
    $error("cic_decimator: ORDER must be 1..3");
  end

  cic_mode_e                   mode_q;
  logic [2:0]                  dec_q, dec_clamped;
  logic [CNT_W-1:0]            cnt, last_cnt;
  logic [CNT_W:0]              r_val;
  logic [1:0]                  warm;
  logic [ORDER-1:0][OUT_W-1:0] integ, integ_nxt;
  logic [OUT_W-1:0]            comb_out;
  logic                        restart, accept, frame_end, cont_end, warmed;

  always_comb begin
    dec_clamped = dec_log2;
    if (dec_log2 == 3'd0)         dec_clamped = 3'd1;
    else if (dec_log2 > DEC_MAX)  dec_clamped = DEC_MAX;
  end

  assign r_val     = (CNT_W+1)'(1) << dec_q;
  assign last_cnt  = CNT_W'(r_val - (CNT_W+1)'(1));
  assign restart   = clear || (mode != mode_q) || (dec_clamped != dec_q);
  assign accept    = in_valid && !restart;
  assign frame_end = accept && (cnt == last_cnt);
  assign cont_end  = frame_end && (mode_q == MODE_CONT);
  assign warmed    = (warm == 2'(ORDER - 1));

  // Chained update i_k' = i_k + i_(k-1)' unrolls to a running prefix sum,
  // which keeps the combinational path free of self-feedback.
  always_comb begin
    logic [OUT_W-1:0] acc;
    acc = OUT_W'(bit_in);
    for (int k = 0; k < ORDER; k++) begin
      acc          = acc + integ[k];
      integ_nxt[k] = acc;
    end
  end

  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    logic [OUT_W-1:0] x, y;
    if (k == 0) begin : g_first
      assign x = integ_nxt[ORDER-1];
    end else begin : g_next
      assign x = g_comb[k-1].y;
    end
    cic_comb_stage #(.W(OUT_W)) u_stage (
      .clk   (clk),
      .reset (reset),
      .clear (restart),
      .en    (cont_end),
      .x     (x),
      .y     (y)
    );
  end

  assign comb_out = g_comb[ORDER-1].y;

  always_ff @(posedge clk) begin
    if (reset) begin
      integ     <= '0;
      cnt       <= '0;
      warm      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      mode_q    <= cic_mode_e'(mode);
      dec_q     <= dec_clamped;
    end else if (restart) begin
      integ     <= '0;
      cnt       <= '0;
      warm      <= '0;
      out_valid <= 1'b0;
      mode_q    <= cic_mode_e'(mode);
      dec_q     <= dec_clamped;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        if (frame_end) begin
          cnt <= '0;
          if (mode_q == MODE_INCR) begin
            integ     <= '0;
            out_data  <= integ_nxt[ORDER-1];
            out_valid <= 1'b1;
          end else begin
            integ <= integ_nxt;
            // Early comb outputs still carry the zero initial history.
            if (warmed) begin
              out_data  <= comb_out;
              out_valid <= 1'b1;
            end else begin
              warm <= warm + 2'd1;
            end
          end
        end else begin
          cnt   <= cnt + CNT_W'(1);
          integ <= integ_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench: ORDER 2/3/1 decimators share stimulus and are compared
// against a closed-form model (binomial-weighted sums, finite differences).
module tb_cic_decimator;

  logic        clk = 1'b0;
  logic        reset = 1'b1, clear = 1'b0, bit_in = 1'b0, in_valid = 1'b0, mode = 1'b0;
  logic [2:0]  dec_log2 = 3'd4;
  logic [15:0] od2, od1;
  logic [19:0] od3;
  logic        ov2, ov3, ov1;

  always #5 clk = ~clk;

  cic_decimator #(.OUT_W(16), .ORDER(2), .LOG2_R_MAX(6)) u_dut (
    .clk(clk), .reset(reset), .clear(clear), .bit_in(bit_in), .in_valid(in_valid),
    .mode(mode), .dec_log2(dec_log2), .out_data(od2), .out_valid(ov2));
  cic_decimator #(.OUT_W(20), .ORDER(3), .LOG2_R_MAX(6)) u_dut_o3 (
    .clk(clk), .reset(reset), .clear(clear), .bit_in(bit_in), .in_valid(in_valid),
    .mode(mode), .dec_log2(dec_log2), .out_data(od3), .out_valid(ov3));
  cic_decimator #(.OUT_W(16), .ORDER(1), .LOG2_R_MAX(6)) u_dut_o1 (
    .clk(clk), .reset(reset), .clear(clear), .bit_in(bit_in), .in_valid(in_valid),
    .mode(mode), .dec_log2(dec_log2), .out_data(od1), .out_valid(ov1));

  logic [31:0] act_d [3];
  logic        act_v [3];
  always_comb begin
    act_d[0] = 32'(od2); act_d[1] = 32'(od3); act_d[2] = 32'(od1);
    act_v[0] = ov2;      act_v[1] = ov3;      act_v[2] = ov1;
  end

  int checks = 0, failures = 0;
  int ORD [3] = '{2, 3, 1};
  int WID [3] = '{16, 20, 16};

  // Model: accepted bits since integrators were last zeroed, sample counts at
  // continuous frame ends, and the expected outputs after the latest edge.
  bit     bits[$];
  int     fends[$];
  int     nacc;
  bit     m_mode;
  int     m_dec;
  longint exp_d [3];
  bit     exp_v [3];

  function automatic int clamp_dec(int d);
    if (d < 1) return 1;
    if (d > 6) return 6;
    return d;
  endfunction

  function automatic longint binom(int n, int i);
    longint c = 1;
    for (int t = 0; t < i; t++) c = c * (n - t) / (t + 1);
    return c;
  endfunction

  // ORDER-fold running sum of the first n bits: bit j contributes C(n-1-j+o-1, o-1).
  function automatic longint integ_val(int o, int n);
    longint s = 0;
    for (int j = 0; j < n; j++) begin
      longint m = n - 1 - j;
      longint w = (o == 1) ? 1 : (o == 2) ? m + 1 : (m + 1) * (m + 2) / 2;
      if (bits[j]) s += w;
    end
    return s;
  endfunction

  // o-th backward difference of the frame-end integrator sequence (zeros before start).
  function automatic longint comb_val(int o);
    longint s = 0;
    int f = fends.size();
    for (int i = 0; i <= o; i++) begin
      if (f - 1 - i >= 0) begin
        longint dv = binom(o, i) * integ_val(o, fends[f-1-i]);
        if (i % 2 == 1) s -= dv; else s += dv;
      end
    end
    return s;
  endfunction

  function automatic void model_step(bit r, bit c, bit m, int d, bit v, bit b);
    int dc = clamp_dec(d);
    for (int k = 0; k < 3; k++) exp_v[k] = 1'b0;
    if (r || c || m != m_mode || dc != m_dec) begin
      bits.delete(); fends.delete(); nacc = 0; m_mode = m; m_dec = dc;
      if (r) for (int k = 0; k < 3; k++) exp_d[k] = 0;
    end else if (v) begin
      bits.push_back(b);
      nacc++;
      if (nacc == (1 << m_dec)) begin
        nacc = 0;
        if (!m_mode) begin
          for (int k = 0; k < 3; k++) begin
            exp_d[k] = integ_val(ORD[k], bits.size()) & ((64'd1 << WID[k]) - 1);
            exp_v[k] = 1'b1;
          end
          bits.delete();
        end else begin
          fends.push_back(bits.size());
          for (int k = 0; k < 3; k++)
            if (fends.size() >= ORD[k]) begin
              exp_d[k] = comb_val(ORD[k]) & ((64'd1 << WID[k]) - 1);
              exp_v[k] = 1'b1;
            end
        end
      end
    end
  endfunction

  task automatic tick(input bit r, input bit c, input bit m, input int d, input bit v, input bit b);
    reset = r; clear = c; mode = m; dec_log2 = 3'(d); in_valid = v; bit_in = b;
    @(posedge clk);
    #1;
    model_step(r, c, m, d, v, b);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) tick(1'b1, 1'($urandom), 1'($urandom), int'($urandom_range(0, 7)),
                      1'($urandom), 1'($urandom));
      else       tick(1'b0, 1'b0, 1'($urandom), int'($urandom_range(0, 7)),
                      1'($urandom), 1'($urandom));
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (act_v[k] !== 1'b0 || act_d[k] !== 32'd0) begin
          failures++;
          $display("FAIL reset o%0d cyc%0d: got v=%0b d=%0d want v=0 d=0", ORD[k], i, act_v[k], act_d[k]);
        end
      end
    end
  endtask

  task automatic test_incr_ones();
    longint want [3] = '{136, 816, 16};
    int first = -1, pulses = 0;
    tick(1'b1, 1'b0, 1'b0, 4, 1'b0, 1'b0);
    for (int i = 0; i < 48; i++) begin
      tick(1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b1);
      if (ov2 === 1'b1) begin pulses++; if (first < 0) first = i + 1; end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (act_v[k] !== exp_v[k] || act_d[k] !== 32'(exp_d[k])) begin
          failures++;
          $display("FAIL incr_ones o%0d cyc%0d: got v=%0b d=%0d want v=%0b d=%0d",
                   ORD[k], i, act_v[k], act_d[k], exp_v[k], exp_d[k]);
        end
      end
    end
    checks++;
    if (first != 16 || pulses != 3) begin
      failures++;
      $display("FAIL incr_timing: got first=%0d pulses=%0d want first=16 pulses=3", first, pulses);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (act_d[k] !== 32'(want[k])) begin
        failures++;
        $display("FAIL incr_value o%0d: got %0d want %0d", ORD[k], act_d[k], want[k]);
      end
    end
  endtask

  task automatic test_cont();
    longint want [3] = '{256, 4096, 16};
    tick(1'b1, 1'b0, 1'b1, 4, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      tick(1'b0, 1'b0, 1'b1, 4, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (act_v[k] !== exp_v[k] || act_d[k] !== 32'(exp_d[k])) begin
          failures++;
          $display("FAIL cont_ones o%0d cyc%0d: got v=%0b d=%0d want v=%0b d=%0d",
                   ORD[k], i, act_v[k], act_d[k], exp_v[k], exp_d[k]);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (act_d[k] !== 32'(want[k])) begin
        failures++;
        $display("FAIL cont_value o%0d: got %0d want %0d", ORD[k], act_d[k], want[k]);
      end
    end
    tick(1'b1, 1'b0, 1'b1, 4, 1'b0, 1'b0);
    for (int i = 0; i < 128; i++) begin
      tick(1'b0, 1'b0, 1'b1, 4, 1'b1, (i < 64) ? (i % 2 == 0) : 1'($urandom));
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (act_v[k] !== exp_v[k] || act_d[k] !== 32'(exp_d[k])) begin
          failures++;
          $display("FAIL cont_pattern o%0d cyc%0d: got v=%0b d=%0d want v=%0b d=%0d",
                   ORD[k], i, act_v[k], act_d[k], exp_v[k], exp_d[k]);
        end
      end
      if (i == 63) begin
        checks++;
        if (od2 !== 16'd128) begin
          failures++;
          $display("FAIL cont_alt: got %0d want 128", od2);
        end
      end
    end
  endtask

  task automatic test_gaps();
    int first = -1;
    tick(1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    for (int i = 0; i < 120; i++) begin
      if (i < 8) tick(1'b0, 1'b0, 1'b0, 2, (i % 2 == 1), 1'b1);
      else       tick(1'b0, 1'b0, 1'b0, 2, ($urandom_range(0, 2) == 0), 1'($urandom));
      if (i < 8 && ov2 === 1'b1 && first < 0) first = i + 1;
      if (i == 7) begin
        checks++;
        if (first != 8 || od2 !== 16'd10) begin
          failures++;
          $display("FAIL gaps_first: got cyc=%0d d=%0d want cyc=8 d=10", first, od2);
        end
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (act_v[k] !== exp_v[k] || act_d[k] !== 32'(exp_d[k])) begin
          failures++;
          $display("FAIL gaps o%0d cyc%0d: got v=%0b d=%0d want v=%0b d=%0d",
                   ORD[k], i, act_v[k], act_d[k], exp_v[k], exp_d[k]);
        end
      end
    end
  endtask

  task automatic test_restart();
    longint prior;
    longint want [3] = '{2080, 45760, 64};
    tick(1'b1, 1'b0, 1'b0, 4, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) tick(1'b0, 1'b0, 1'b0, 4, 1'b1, 1'($urandom));
    prior = exp_d[0];
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b1);
    checks++;
    if (ov2 !== 1'b0 || 64'(od2) !== prior) begin
      failures++;
      $display("FAIL clear_hold: got v=%0b d=%0d want v=0 d=%0d", ov2, od2, prior);
    end
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (act_v[k] !== exp_v[k] || act_d[k] !== 32'(exp_d[k])) begin
          failures++;
          $display("FAIL clear o%0d cyc%0d: got v=%0b d=%0d want v=%0b d=%0d",
                   ORD[k], i, act_v[k], act_d[k], exp_v[k], exp_d[k]);
        end
      end
    end
    checks++;
    if (ov2 !== 1'b1 || od2 !== 16'd136) begin
      failures++;
      $display("FAIL clear_next: got v=%0b d=%0d want v=1 d=136", ov2, od2);
    end
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b1);
    for (int i = 0; i < 65; i++) begin
      tick(1'b0, 1'b0, 1'b0, 7, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (act_v[k] !== exp_v[k] || act_d[k] !== 32'(exp_d[k])) begin
          failures++;
          $display("FAIL dec_change o%0d cyc%0d: got v=%0b d=%0d want v=%0b d=%0d",
                   ORD[k], i, act_v[k], act_d[k], exp_v[k], exp_d[k]);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (act_d[k] !== 32'(want[k])) begin
        failures++;
        $display("FAIL dec_value o%0d: got %0d want %0d", ORD[k], act_d[k], want[k]);
      end
    end
  endtask

  task automatic test_cont_r64();
    longint want [3] = '{4096, 262144, 64};
    tick(1'b1, 1'b0, 1'b1, 6, 1'b0, 1'b0);
    for (int i = 0; i < 192; i++) tick(1'b0, 1'b0, 1'b1, 6, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (act_v[k] !== 1'b1 || act_d[k] !== 32'(want[k])) begin
        failures++;
        $display("FAIL cont_r64 o%0d: got v=%0b d=%0d want v=1 d=%0d", ORD[k], act_v[k], act_d[k], want[k]);
      end
    end
  endtask

  task automatic test_random();
    bit m = 1'b0;
    int d = 3;
    tick(1'b1, 1'b0, m, d, 1'b0, 1'b0);
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) m = ~m;
      if ($urandom_range(0, 299) == 0) d = int'($urandom_range(0, 7));
      tick(($urandom_range(0, 499) == 0), ($urandom_range(0, 249) == 0), m, d,
           ($urandom_range(0, 3) != 0), 1'($urandom));
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (act_v[k] !== exp_v[k] || act_d[k] !== 32'(exp_d[k])) begin
          failures++;
          $display("FAIL random o%0d cyc%0d: got v=%0b d=%0d want v=%0b d=%0d",
                   ORD[k], i, act_v[k], act_d[k], exp_v[k], exp_d[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_incr_ones();
    test_cont();
    test_gaps();
    test_restart();
    test_cont_r64();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
